// File: rtl/bp_me_nonsynth_mem_responder_if.sv
// BedRock cce mem_cmd/mem_resp channel pair between a cache test wrapper and a memory responder.
// Header fields travel as separate signals; _i/_o suffixes are from the responder's point of view.
interface bp_me_nonsynth_mem_responder_if
  #(parameter int paddr_width_p     = 40
  , parameter int cce_block_width_p = 512
  , parameter int payload_width_p   = 7
  );

  logic [3:0]                   mem_cmd_msg_type_i;
  logic [paddr_width_p-1:0]     mem_cmd_addr_i;
  logic [2:0]                   mem_cmd_size_i;
  logic [payload_width_p-1:0]   mem_cmd_payload_i;
  logic [cce_block_width_p-1:0] mem_cmd_data_i;
  logic                         mem_cmd_v_i;
  logic                         mem_cmd_ready_and_o;

  logic [3:0]                   mem_resp_msg_type_o;
  logic [paddr_width_p-1:0]     mem_resp_addr_o;
  logic [2:0]                   mem_resp_size_o;
  logic [payload_width_p-1:0]   mem_resp_payload_o;
  logic [cce_block_width_p-1:0] mem_resp_data_o;
  logic                         mem_resp_v_o;
  logic                         mem_resp_yumi_i;

  modport master (
    output mem_cmd_msg_type_i, mem_cmd_addr_i, mem_cmd_size_i, mem_cmd_payload_i,
           mem_cmd_data_i, mem_cmd_v_i, mem_resp_yumi_i,
    input  mem_cmd_ready_and_o, mem_resp_msg_type_o, mem_resp_addr_o, mem_resp_size_o,
           mem_resp_payload_o, mem_resp_data_o, mem_resp_v_o
  );

  modport slave (
    input  mem_cmd_msg_type_i, mem_cmd_addr_i, mem_cmd_size_i, mem_cmd_payload_i,
           mem_cmd_data_i, mem_cmd_v_i, mem_resp_yumi_i,
    output mem_cmd_ready_and_o, mem_resp_msg_type_o, mem_resp_addr_o, mem_resp_size_o,
           mem_resp_payload_o, mem_resp_data_o, mem_resp_v_o
  );

endinterface

// File: rtl/bp_me_nonsynth_mem_responder.sv
// Single-outstanding BedRock memory responder with a block-wide backing array and a fixed
// response latency; used as a deterministic-latency memory for D$ unit benches.
module bp_me_nonsynth_mem_responder
  #(parameter int          paddr_width_p     = 40
  , parameter int          cce_block_width_p = 512
  , parameter int          lce_id_width_p    = 4
  , parameter int          lce_assoc_p       = 8
  , parameter int          mem_els_p         = 1024
  , parameter int          latency_p         = 4
  , parameter logic [31:0] offset_p          = 32'h8000_0000
  )
  (input logic                              clk_i
  , input logic                             reset_i
  , bp_me_nonsynth_mem_responder_if.slave   mem_if
  );

  localparam int block_bytes_lp    = cce_block_width_p / 8;
  localparam int lg_block_bytes_lp = $clog2(block_bytes_lp);
  localparam int lg_els_lp         = $clog2(mem_els_p);
  localparam int payload_width_lp  = lce_id_width_p + $clog2(lce_assoc_p);
  localparam logic [7:0] last_cnt_lp = (latency_p > 0) ? 8'(latency_p - 1) : 8'd0;

  localparam logic [3:0] e_bedrock_mem_rd    = 4'd0;
  localparam logic [3:0] e_bedrock_mem_wr    = 4'd1;
  localparam logic [3:0] e_bedrock_mem_uc_rd = 4'd2;
  localparam logic [3:0] e_bedrock_mem_uc_wr = 4'd3;

  typedef enum logic [1:0] {e_reset, e_ready, e_wait, e_resp} state_e;

  state_e                        r_state;
  logic [7:0]                    r_cnt;
  logic                          r_ready;
  logic                          r_resp_v;

  logic [3:0]                    r_msg_type;
  logic [paddr_width_p-1:0]      r_addr;
  logic [2:0]                    r_size;
  logic [payload_width_lp-1:0]   r_payload;
  logic                          r_is_rd;
  logic [lg_block_bytes_lp-1:0]  r_off;
  logic [lg_block_bytes_lp-1:0]  r_amask;
  logic [cce_block_width_p-1:0]  r_rd_block;

  // Contents start at zero and are deliberately untouched by reset_i.
  logic [cce_block_width_p-1:0]  r_mem [mem_els_p] = '{default: '0};

  logic                          w_accept;
  logic                          w_is_wr;
  logic                          w_is_rd;
  logic [lg_els_lp-1:0]          w_cmd_idx;
  logic [3:0]                    w_cmd_lg;
  logic [lg_block_bytes_lp-1:0]  w_cmd_amask;
  logic [lg_block_bytes_lp-1:0]  w_cmd_off;
  logic [block_bytes_lp-1:0]     w_wr_be;
  logic [block_bytes_lp-1:0][7:0] w_wr_data;
  logic [block_bytes_lp-1:0][7:0] w_resp_byte;

  assign w_accept = mem_if.mem_cmd_v_i & r_ready & ~reset_i;
  assign w_is_wr  = (mem_if.mem_cmd_msg_type_i == e_bedrock_mem_wr)
                  | (mem_if.mem_cmd_msg_type_i == e_bedrock_mem_uc_wr);
  assign w_is_rd  = (mem_if.mem_cmd_msg_type_i == e_bedrock_mem_rd)
                  | (mem_if.mem_cmd_msg_type_i == e_bedrock_mem_uc_rd);

  // Addresses outside the array alias modulo mem_els_p by simple truncation.
  assign w_cmd_idx = lg_els_lp'((mem_if.mem_cmd_addr_i - paddr_width_p'(offset_p)) >> lg_block_bytes_lp);

  // Access size is clamped to one block; offset is aligned down to the access size.
  assign w_cmd_lg    = ({1'b0, mem_if.mem_cmd_size_i} > 4'(lg_block_bytes_lp))
                     ? 4'(lg_block_bytes_lp) : {1'b0, mem_if.mem_cmd_size_i};
  assign w_cmd_amask = lg_block_bytes_lp'((32'd1 << w_cmd_lg) - 32'd1);
  assign w_cmd_off   = mem_if.mem_cmd_addr_i[lg_block_bytes_lp-1:0] & ~w_cmd_amask;

  // Byte gi of the field is byte (gi & amask) of the access; reads replicate that field.
  for (genvar gi = 0; gi < block_bytes_lp; gi++) begin : g_byte
    assign w_wr_be[gi]     = ((lg_block_bytes_lp'(gi) & ~w_cmd_amask) == w_cmd_off);
    assign w_wr_data[gi]   = mem_if.mem_cmd_data_i[8*int'(lg_block_bytes_lp'(gi) & w_cmd_amask) +: 8];
    assign w_resp_byte[gi] = r_is_rd
                           ? r_rd_block[8*int'(r_off | (lg_block_bytes_lp'(gi) & r_amask)) +: 8]
                           : 8'h00;
  end

  always_ff @(posedge clk_i) begin
    if (w_accept && w_is_wr) begin
      for (int b = 0; b < block_bytes_lp; b++) begin
        if (w_wr_be[b]) begin
          r_mem[w_cmd_idx][8*b +: 8] <= w_wr_data[b];
        end
      end
    end
    if (w_accept) begin
      r_rd_block <= r_mem[w_cmd_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_msg_type <= mem_if.mem_cmd_msg_type_i;
      r_addr     <= mem_if.mem_cmd_addr_i;
      r_size     <= mem_if.mem_cmd_size_i;
      r_payload  <= mem_if.mem_cmd_payload_i;
      r_is_rd    <= w_is_rd;
      r_off      <= w_cmd_off;
      r_amask    <= w_cmd_amask;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state  <= e_reset;
      r_cnt    <= 8'd0;
      r_ready  <= 1'b0;
      r_resp_v <= 1'b0;
    end else begin
      case (r_state)
        e_reset: begin
          r_state <= e_ready;
          r_ready <= 1'b1;
        end
        e_ready: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            if (latency_p > 0) begin
              r_state <= e_wait;
            end else begin
              r_state  <= e_resp;
              r_resp_v <= 1'b1;
            end
          end
        end
        e_wait: begin
          if (r_cnt == last_cnt_lp) begin
            r_cnt    <= 8'd0;
            r_state  <= e_resp;
            r_resp_v <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        e_resp: begin
          // Ready is registered, so the next command lands no earlier than the cycle after yumi.
          if (mem_if.mem_resp_yumi_i) begin
            r_state  <= e_ready;
            r_resp_v <= 1'b0;
            r_ready  <= 1'b1;
          end
        end
        default: begin
          r_state  <= e_reset;
          r_ready  <= 1'b0;
          r_resp_v <= 1'b0;
        end
      endcase
    end
  end

  always @(posedge clk_i) begin
    assert (reset_i || !mem_if.mem_resp_yumi_i || r_resp_v)
      else $error("mem_resp_yumi_i asserted while mem_resp_v_o is low");
  end

  assign mem_if.mem_cmd_ready_and_o = r_ready;
  assign mem_if.mem_resp_v_o        = r_resp_v;
  assign mem_if.mem_resp_msg_type_o = r_msg_type;
  assign mem_if.mem_resp_addr_o     = r_addr;
  assign mem_if.mem_resp_size_o     = r_size;
  assign mem_if.mem_resp_payload_o  = r_payload;
  assign mem_if.mem_resp_data_o     = w_resp_byte;

endmodule
